// File: rtl/cla_addsub_pipe_pkg.sv
// Shared definitions for the pipelined CLA add/sub/reduce unit.
// Operation encoding as seen on the op port.
package cla_addsub_pipe_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_PADDSB = 2'b10,
    OP_RED    = 2'b11
  } op_e;

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for cla_addsub_pipe.
// master = producer/consumer side, slave = the arithmetic unit.
interface cla_addsub_pipe_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_v
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_v
  );

endinterface

// File: rtl/cla_addsub_pipe_cla_lane.sv
// W-bit carry-lookahead lane: sum with carry-in, plus group propagate,
// group generate (carry-in independent) and carry-out.
module cla_lane #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         p_o,
  output logic         g_o,
  output logic         cout_o
);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;
  logic         gg;

  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c    = '0;
    c[0] = cin_i;
    gg   = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      gg     = g[i] | (p[i] & gg);
    end
    sum_o  = p ^ c[W-1:0];
    p_o    = &p;
    g_o    = gg;
    cout_o = c[W];
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined ADD/SUB/PADDSB/RED unit built from CLA lanes, with Z/N/V flags.
// Define ADDER_SAT_EN to make ADD/SUB clamp on signed overflow instead of wrapping.
module cla_addsub_pipe
  import cla_addsub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LANE_W = 4,
  parameter int unsigned RED_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cla_addsub_pipe_if.slave  io
);

  localparam int unsigned NL  = WIDTH / LANE_W;
  localparam int unsigned NC  = WIDTH / RED_W;
  localparam int unsigned LPC = RED_W / LANE_W;
  localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};
`ifdef ADDER_SAT_EN
  localparam logic [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv;

  assign s2_adv      = !s2_valid_q || io.out_ready;
  assign s1_adv      = !s1_valid_q || s2_adv;
  assign io.in_ready = s1_adv;

  // Stage 1: independent lane sums
  op_e              op_in;
  logic             sub_in;
  logic [WIDTH-1:0] b_eff;
  logic [NL-1:0]    lane_cin;

  logic [NL-1:0][LANE_W-1:0] s1_sum_d, s1_sum_q;
  logic [NL-1:0]             s1_p_d, s1_p_q;
  logic [NL-1:0]             s1_g_d, s1_g_q;
  logic [NL-1:0]             s1_cout_d, s1_cout_q;
  logic [NL-1:0]             s1_amsb_d, s1_amsb_q;
  logic [NL-1:0]             s1_bmsb_d, s1_bmsb_q;
  op_e                       s1_op_q;

  assign op_in  = op_e'(io.op);
  assign sub_in = (op_in == OP_SUB);
  assign b_eff  = sub_in ? ~io.b : io.b;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    // Only lane 0 sees the subtract carry-in; upper lanes are fixed up in S2.
    assign lane_cin[i]  = (i == 0) ? sub_in : 1'b0;
    assign s1_amsb_d[i] = io.a[i*LANE_W + LANE_W-1];
    assign s1_bmsb_d[i] = b_eff[i*LANE_W + LANE_W-1];

    cla_lane #(.W(LANE_W)) u_lane (
      .a_i    (io.a[i*LANE_W +: LANE_W]),
      .b_i    (b_eff[i*LANE_W +: LANE_W]),
      .cin_i  (lane_cin[i]),
      .sum_o  (s1_sum_d[i]),
      .p_o    (s1_p_d[i]),
      .g_o    (s1_g_d[i]),
      .cout_o (s1_cout_d[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_cout_q  <= '0;
      s1_amsb_q  <= '0;
      s1_bmsb_q  <= '0;
      s1_op_q    <= OP_ADD;
    end else if (s1_adv) begin
      s1_valid_q <= io.in_valid;
      if (io.in_valid) begin
        s1_sum_q  <= s1_sum_d;
        s1_p_q    <= s1_p_d;
        s1_g_q    <= s1_g_d;
        s1_cout_q <= s1_cout_d;
        s1_amsb_q <= s1_amsb_d;
        s1_bmsb_q <= s1_bmsb_d;
        s1_op_q   <= op_in;
      end
    end
  end

  // Stage 2: carry resolve, saturation, reduction, flags
  logic [NL:0]       c;
  logic [WIDTH-1:0]  sum_as, pad, red, chunk;
  logic [LANE_W-1:0] lane;
  logic              ovf, v_as, v_pad;
  logic [WIDTH-1:0]  res_d, res_q;
  logic              z_d, n_d, v_d;
  logic              z_q, n_q, v_q;

  always_comb begin
    c      = '0;
    c[0]   = (s1_op_q == OP_SUB);
    sum_as = '0;
    pad    = '0;
    red    = '0;
    chunk  = '0;
    lane   = '0;
    ovf    = 1'b0;
    v_pad  = 1'b0;

    for (int unsigned i = 0; i < NL; i++) begin
      c[i+1] = s1_g_q[i] | (s1_p_q[i] & c[i]);
    end

    for (int unsigned i = 0; i < NL; i++) begin
      lane = s1_sum_q[i];
      sum_as[i*LANE_W +: LANE_W] = (i == 0) ? lane : lane + {{(LANE_W-1){1'b0}}, c[i]};
      ovf   = (s1_amsb_q[i] == s1_bmsb_q[i]) && (lane[LANE_W-1] != s1_amsb_q[i]);
      v_pad = v_pad | ovf;
      pad[i*LANE_W +: LANE_W] = ovf ? (s1_amsb_q[i] ? LANE_MIN : LANE_MAX) : lane;
    end

    // Signed overflow = carry into MSB ^ carry out, with carry-in recovered from the operand MSBs.
    v_as = s1_amsb_q[NL-1] ^ s1_bmsb_q[NL-1] ^ sum_as[WIDTH-1] ^ c[NL];
`ifdef ADDER_SAT_EN
    if (v_as) sum_as = s1_amsb_q[NL-1] ? W_MIN : W_MAX;
`endif

    // Each chunk pair: unsigned lane sums with carries, minus 2^RED_W per negative operand chunk.
    for (int unsigned k = 0; k < NC; k++) begin
      chunk = '0;
      for (int unsigned j = 0; j < LPC; j++) begin
        chunk = chunk + (WIDTH'({s1_cout_q[k*LPC+j], s1_sum_q[k*LPC+j]}) << (j*LANE_W));
      end
      red = red + chunk
                - (WIDTH'(s1_amsb_q[k*LPC+LPC-1]) << RED_W)
                - (WIDTH'(s1_bmsb_q[k*LPC+LPC-1]) << RED_W);
    end

    res_d = sum_as;
    v_d   = v_as;
    case (s1_op_q)
      OP_ADD, OP_SUB: begin
        res_d = sum_as;
        v_d   = v_as;
      end
      OP_PADDSB: begin
        res_d = pad;
        v_d   = v_pad;
      end
      OP_RED: begin
        res_d = red;
        v_d   = 1'b0;
      end
      default: begin
        res_d = sum_as;
        v_d   = v_as;
      end
    endcase
    z_d = (res_d == '0);
    n_d = res_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      v_q        <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q <= res_d;
        z_q   <= z_d;
        n_q   <= n_d;
        v_q   <= v_d;
      end
    end
  end

  assign io.out_valid = s2_valid_q;
  assign io.result    = res_q;
  assign io.flag_z    = z_q;
  assign io.flag_n    = n_q;
  assign io.flag_v    = v_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe (WIDTH=16, LANE_W=4, RED_W=8).
// Expected results come from an integer-arithmetic model; a monitor compares in order.
module tb_cla_addsub_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_addsub_pipe_if #(.WIDTH(16)) io ();

  cla_addsub_pipe #(.WIDTH(16), .LANE_W(4), .RED_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        v;
    bit          lat;
    int          cyc;
  } sb_ent_t;

  sb_ent_t sb[$];
  sb_ent_t mon_ent;
  int      n_checks = 0;
  int      n_pass   = 0;
  bit      lat_next = 1'b0;
  bit      rand_en  = 1'b0;

  logic [15:0] edge_tab [9] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF,
                                16'h8080, 16'h7F7F, 16'h7777, 16'h8888};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sx4(input logic [3:0] x);
    return (x >= 4'd8) ? int'(x) - 16 : int'(x);
  endfunction

  function automatic sb_ent_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    sb_ent_t     e;
    int          s;
    int          ls;
    logic [15:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        s = (op == 2'b00) ? int'($signed(a)) + int'($signed(b))
                          : int'($signed(a)) - int'($signed(b));
        v = (s > 32767) || (s < -32768);
        r = s[15:0];
`ifdef ADDER_SAT_EN
        if (s > 32767)       r = 16'h7FFF;
        else if (s < -32768) r = 16'h8000;
`endif
      end
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          ls = sx4(a[i*4 +: 4]) + sx4(b[i*4 +: 4]);
          if (ls > 7)       begin ls = 7;  v = 1'b1; end
          else if (ls < -8) begin ls = -8; v = 1'b1; end
          r[i*4 +: 4] = ls[3:0];
        end
      end
      default: begin
        s = 0;
        for (int i = 0; i < 2; i++)
          s = s + int'($signed(a[i*8 +: 8])) + int'($signed(b[i*8 +: 8]));
        r = s[15:0];
      end
    endcase
    e.res = r;
    e.z   = (r == 16'h0000);
    e.n   = r[15];
    e.v   = v;
    e.lat = 1'b0;
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: records accepts, compares every presented output against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (io.out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", {31'b0, io.out_valid}, 32'd0);
        end else begin
          mon_ent = sb[0];
          check("result", {16'b0, io.result}, {16'b0, mon_ent.res});
          check("flag_z", {31'b0, io.flag_z}, {31'b0, mon_ent.z});
          check("flag_n", {31'b0, io.flag_n}, {31'b0, mon_ent.n});
          check("flag_v", {31'b0, io.flag_v}, {31'b0, mon_ent.v});
          if (io.out_ready) begin
            if (mon_ent.lat) check("latency", cyc - mon_ent.cyc, 32'd2);
            void'(sb.pop_front());
          end
        end
      end
      if (io.in_valid && io.in_ready) begin
        mon_ent     = model(io.op, io.a, io.b);
        mon_ent.lat = lat_next;
        mon_ent.cyc = cyc;
        sb.push_back(mon_ent);
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    io.in_valid = 1'b1;
    io.op       = op;
    io.a        = a;
    io.b        = b;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    bit done;
    done = 1'b0;
    drive(op, a, b);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (io.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    io.in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    io.in_valid  = 1'b0;
    io.op        = 2'b00;
    io.a         = '0;
    io.b         = '0;
    io.out_ready = 1'b1;

    // Reset state
    #13;
    check("rst_out_valid", {31'b0, io.out_valid}, 32'd0);
    check("rst_result",    {16'b0, io.result},    32'd0);
    check("rst_flags",     {29'b0, io.flag_z, io.flag_n, io.flag_v}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    check("in_ready_idle", {31'b0, io.in_ready}, 32'd1);

    // Directed cases
    send(2'b00, 16'h7FFF, 16'h0001);
    idle(3);
    lat_next = 1'b1;
    send(2'b01, 16'h0005, 16'h0005);
    lat_next = 1'b0;
    idle(3);
    send(2'b10, 16'h7781, 16'h1188);
    send(2'b11, 16'h7F7F, 16'h7F7F);
    send(2'b11, 16'h8080, 16'h8080);
    send(2'b01, 16'h8000, 16'h0001);
    send(2'b00, 16'hFFFF, 16'h0001);
    send(2'b00, 16'h8000, 16'h8000);
    send(2'b10, 16'h8888, 16'h8888);
    idle(4);

    // Back-pressure: two accepts fill both stages, third must wait
    io.out_ready = 1'b0;
    send(2'b00, 16'h1234, 16'h4321);
    send(2'b01, 16'h0100, 16'h0200);
    drive(2'b10, 16'h7777, 16'h7777);
    @(negedge clk);
    check("in_ready_full", {31'b0, io.in_ready}, 32'd0);
    @(negedge clk);
    check("in_ready_full2", {31'b0, io.in_ready}, 32'd0);
    check("out_valid_stall", {31'b0, io.out_valid}, 32'd1);
    @(posedge clk); #1;
    io.out_ready = 1'b1;
    send(2'b10, 16'h7777, 16'h7777);
    send(2'b11, 16'hFF01, 16'h80FF);
    idle(4);

    // Reset with both stages full
    io.out_ready = 1'b0;
    send(2'b00, 16'h0F0F, 16'h0101);
    send(2'b00, 16'h2222, 16'h3333);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, io.out_valid}, 32'd0);
    check("midrst_result",    {16'b0, io.result},    32'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_no_stale", {31'b0, io.out_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Randomized stream with random back-pressure
    rand_en = 1'b1;
    fork
      begin
        while (rand_en) begin
          @(posedge clk);
          #1;
          io.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 8)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 8)] : 16'($urandom);
      send(2'($urandom_range(0, 3)), ra, rb);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_en = 1'b0;
    @(posedge clk); #2;
    io.out_ready = 1'b1;

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
